// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: 5..MAX_DATA_BITS data bits, none/even/odd parity, 1 or 2 stop bits.
// A valid/ready handshake latches payload and line config; a one-cycle done pulse marks the frame end.
module uart_tx_param #(
  parameter int MAX_DATA_BITS = 8,
  parameter int CPB_WIDTH     = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic [CPB_WIDTH-1:0]     i_Clocks_per_Bit,
  input  logic [3:0]               i_Data_Bits,
  input  logic [1:0]               i_Parity_Mode,
  input  logic                     i_Two_Stop,
  input  logic                     i_Tx_Valid,
  input  logic [MAX_DATA_BITS-1:0] i_Tx_Data,
  output logic                     o_Tx_Ready,
  output logic                     o_Tx_Serial,
  output logic                     o_Tx_Active,
  output logic                     o_Tx_Done
);

  localparam logic [3:0] MAX_NB = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic [MAX_DATA_BITS-1:0] width_mask(input logic [3:0] n);
    logic [MAX_DATA_BITS-1:0] m;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      m[i] = (4'(i) < n);
    end
    return m;
  endfunction

  function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] d);
    return ^d;
  endfunction

  state_e                   state_q, state_d;
  logic [CPB_WIDTH-1:0]     cnt_q, cnt_d;
  logic [CPB_WIDTH-1:0]     cpb_m1_q, cpb_m1_d;
  logic [3:0]               idx_q, idx_d;
  logic [3:0]               nbits_q, nbits_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic                     two_stop_q, two_stop_d;
  logic                     serial_q, serial_d;
  logic                     ready_q, ready_d;
  logic                     active_q, active_d;
  logic                     done_q, done_d;

  logic [3:0]               nbits_s;
  logic [CPB_WIDTH-1:0]     cpb_m1_s;
  logic [MAX_DATA_BITS-1:0] payload_s;
  logic                     accept_s;
  logic                     bit_end_s;

  // Clamp the incoming configuration to legal values before it is latched.
  always_comb begin
    if (i_Data_Bits < 4'd5) begin
      nbits_s = 4'd5;
    end else if (i_Data_Bits > MAX_NB) begin
      nbits_s = MAX_NB;
    end else begin
      nbits_s = i_Data_Bits;
    end
    if (i_Clocks_per_Bit == '0) begin
      cpb_m1_s = '0;
    end else begin
      cpb_m1_s = i_Clocks_per_Bit - CPB_WIDTH'(1);
    end
  end

  assign payload_s = i_Tx_Data & width_mask(nbits_s);
  assign accept_s  = i_Tx_Valid && ready_q;
  assign bit_end_s = (cnt_q == cpb_m1_q);

  // Next-state and next-output logic; outputs are registered with the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    cpb_m1_d   = cpb_m1_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    serial_d   = serial_q;
    ready_d    = ready_q;
    active_d   = active_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        serial_d = 1'b1;
        ready_d  = 1'b1;
        active_d = 1'b0;
        if (accept_s) begin
          state_d    = S_START;
          cnt_d      = '0;
          idx_d      = 4'd0;
          shift_d    = payload_s;
          nbits_d    = nbits_s;
          cpb_m1_d   = cpb_m1_s;
          par_en_d   = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
          par_bit_d  = even_parity(payload_s) ^ (i_Parity_Mode == 2'b10);
          two_stop_d = i_Two_Stop;
          serial_d   = 1'b0;
          ready_d    = 1'b0;
          active_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d  = S_DATA;
          cnt_d    = '0;
          idx_d    = 4'd0;
          serial_d = shift_q[0];
          shift_d  = shift_q >> 4'd1;
        end else begin
          cnt_d = cnt_q + CPB_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == nbits_q - 4'd1) begin
            idx_d = 4'd0;
            if (par_en_q) begin
              state_d  = S_PARITY;
              serial_d = par_bit_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 4'd1;
            serial_d = shift_q[0];
            shift_d  = shift_q >> 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CPB_WIDTH'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d  = S_STOP;
          cnt_d    = '0;
          idx_d    = 4'd0;
          serial_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CPB_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          // idx counts completed stop bits; the last one hands over to DONE
          if (idx_q == {3'd0, two_stop_q}) begin
            state_d  = S_DONE;
            idx_d    = 4'd0;
            serial_d = 1'b1;
            done_d   = 1'b1;
            ready_d  = 1'b1;
            active_d = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CPB_WIDTH'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        idx_d    = 4'd0;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame immediately.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cpb_m1_q   <= '0;
      idx_q      <= 4'd0;
      nbits_q    <= MAX_NB;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
      ready_q    <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpb_m1_q   <= cpb_m1_d;
      idx_q      <= idx_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      serial_q   <= serial_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule
